// File: rtl/rv_lsu_if.sv
// Core-side request/response and memory-side beat bundle for rv_lsu.
// slave: the LSU view; master: the core/memory environment view.
interface rv_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_fault, mem_req, mem_we,
    output mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_fault, mem_req, mem_we,
    input  mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/rv_lsu.sv
// RISC-V load/store unit: one request -> one or two word beats -> one response.
// Ports: clk, reset (sync active-low), bus (rv_lsu_if.slave: req/rsp/mem).
module rv_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT        = 255,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic    clk,
  input  logic    reset,
  rv_lsu_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1, RESP
  } state_t;

  localparam int CNT_W =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       beat0_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_clr, cnt_inc, beat0_ld;
  logic              accept, mis_in, illegal_in;
  logic              split_q;
  logic [1:0]        off_in, off_q;
  logic [3:0]        size_m;
  logic [7:0]        be_w;
  logic [63:0]       wd_w;
  logic [ADDR_W-1:0] word_a;

  function automatic logic [31:0] merge(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] b1,
    input logic [31:0] b0
  );
    logic [63:0] s;
    s = {b1, b0} >> {off, 3'b000};
    case (f3)
      3'b000:  merge = {{24{s[7]}}, s[7:0]};
      3'b001:  merge = {{16{s[15]}}, s[15:0]};
      3'b100:  merge = {24'h0, s[7:0]};
      3'b101:  merge = {16'h0, s[15:0]};
      default: merge = s[31:0];
    endcase
  endfunction

  assign off_in = bus.req_addr[1:0];
  assign off_q  = addr_q[1:0];
  assign accept = (state_q == IDLE) && bus.req_valid;

  always_comb begin
    mis_in = 1'b0;
    unique case (1'b1)
      bus.req_funct3[1:0] == 2'b01:
        mis_in = (off_in == 2'b11);
      bus.req_funct3[1:0] == 2'b10:
        mis_in = (off_in != 2'b00);
      default: mis_in = 1'b0;
    endcase
  end

  assign illegal_in =
    (bus.req_funct3 == 3'b011) ||
    (bus.req_funct3[2:1] == 2'b11) ||
    (bus.req_we && bus.req_funct3[2]) ||
    (mis_in && (MISALIGN_SPLIT == 0));

  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_m = 4'b0001;
      2'b01:   size_m = 4'b0011;
      default: size_m = 4'b1111;
    endcase
  end

  // Upper halves of the shifted mask/data spill into the next word.
  assign be_w    = {4'b0000, size_m} << off_q;
  assign wd_w    = {32'h0, wdata_q} << {off_q, 3'b000};
  assign split_q = |be_w[7:4];
  assign word_a  = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    rdata_d       = rdata_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    beat0_ld      = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_fault = 1'b0;
    bus.rsp_rdata = 32'h0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = 4'b0000;
    bus.mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          fault_d = illegal_in;
          rdata_d = 32'h0;
          cnt_clr = 1'b1;
          state_d = illegal_in ? RESP : BEAT0;
        end
      end
      BEAT0, BEAT1: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = we_q;
        if (state_q == BEAT0) begin
          bus.mem_addr  = word_a;
          bus.mem_be    = be_w[3:0];
          bus.mem_wdata = wd_w[31:0];
        end else begin
          bus.mem_addr  = word_a + ADDR_W'(4);
          bus.mem_be    = be_w[7:4];
          bus.mem_wdata = wd_w[63:32];
        end
        if (bus.mem_ack) begin
          cnt_clr = 1'b1;
          if (state_q == BEAT0) beat0_ld = 1'b1;
          if (state_q == BEAT0 && split_q) begin
            state_d = BEAT1;
          end else begin
            state_d = RESP;
            if (!we_q) begin
              rdata_d = (state_q == BEAT0)
                ? merge(f3_q, off_q, 32'h0, bus.mem_rdata)
                : merge(f3_q, off_q, bus.mem_rdata, beat0_q);
            end
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This would be the TIMEOUT-th unacked cycle: give up now.
          state_d = RESP;
          fault_d = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_fault = fault_q;
        bus.rsp_rdata = rdata_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      beat0_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (beat0_ld) beat0_q <= bus.mem_rdata;
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule
